multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: per-state datapath controls, bounded memory
// waits with a sticky fault, syscall handshake and a retired-instruction counter.
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             syscall_ack,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             invert_zero,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             syscall_req,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_SYSCALL  = 4'd12,
    S_FAULT    = 4'd13
  } state_e;

  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout;

  assign timeout     = (wait_q == MAX_WAIT_W);
  assign state       = state_q;
  assign instr_count = count_q;

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    count_d       = count_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    invert_zero   = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    syscall_req   = 1'b0;
    fault         = 1'b0;

    // wait_d defaults to zero, so any state change clears the wait counter
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (op)
          6'h00:        state_d = (funct == 6'h0C) ? S_SYSCALL : S_R_EXEC;
          6'h23, 6'h2B: state_d = S_MEM_ADDR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h08, 6'h0D: state_d = S_I_EXEC;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_FAULT;
        else              wait_d  = wait_q + 8'd1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        count_d    = count_q + CNT_W'(1);
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          count_d = count_q + CNT_W'(1);
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
        count_d   = count_q + CNT_W'(1);
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op == 6'h0D) ? 2'b11 : 2'b00;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        count_d   = count_q + CNT_W'(1);
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        invert_zero   = (op == 6'h05);
        state_d       = S_FETCH;
        count_d       = count_q + CNT_W'(1);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
        count_d   = count_q + CNT_W'(1);
      end
      S_SYSCALL: begin
        syscall_req = 1'b1;
        if (syscall_ack) begin
          state_d = S_FETCH;
          count_d = count_q + CNT_W'(1);
        end
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes per-cycle expectations
// derived from instruction-level rules; a negedge monitor pops and compares.
module tb_multicycle_control;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;

  logic clock = 1'b0, reset_n = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic mem_ready = 1'b0, syscall_ack = 1'b0;
  logic pc_write, pc_write_cond, invert_zero, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, syscall_req, fault;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;

  always #5 clock = ~clock;

  multicycle_control #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .op(op), .funct(funct),
    .mem_ready(mem_ready), .syscall_ack(syscall_ack),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .invert_zero(invert_zero),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .syscall_req(syscall_req),
    .fault(fault), .instr_count(instr_count)
  );

  typedef struct {
    int         st;
    logic       mr;
    logic [5:0] o;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Control table per state, in port order; Mealy FETCH strobes follow mem_ready.
  function automatic logic [18:0] exp_ctrl(int st, logic mr, logic [5:0] o);
    logic pcw = 0, pcwc = 0, inv = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, asa = 0, sreq = 0, flt = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; inv = (o == 6'h05); end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; aop = (o == 6'h0D) ? 2'b11 : 2'b00; end
      11: rw = 1;
      12: sreq = 1;
      13: flt = 1;
      default: ;
    endcase
    return {pcw, pcwc, inv, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, sreq, flt};
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ctrl", 32'({pc_write, pc_write_cond, invert_zero, iord, mem_read, mem_write,
                         ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                         alu_op, pc_source, syscall_req, fault}),
            32'(exp_ctrl(e.st, e.mr, e.o)));
      check("instr_count", 32'(instr_count), 32'(e.cnt));
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(int st, logic mr, logic ack, bit done);
    exp_t e;
    mem_ready   = mr;
    syscall_ack = ack;
    e.st = st; e.mr = mr; e.o = op; e.cnt = model_cnt;
    exp_q.push_back(e);
    @(posedge clock); #1;
    if (done) model_cnt = (model_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic do_reset();
    mem_ready   = 1'b0;
    syscall_ack = 1'b0;
    reset_n     = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_sysreq", 32'(syscall_req), 32'd0);
    @(posedge clock); #1;
    check("rst_hold_state", 32'(state), 32'd0);
    reset_n   = 1'b1;
    model_cnt = 0;
  endtask

  // fw/mw: mem_ready low cycles in FETCH / memory state; aw: ack low cycles in SYSCALL
  task automatic run_instr(logic [5:0] o, logic [5:0] f, int fw, int mw, int aw);
    op = o; funct = f;
    for (int i = 0; i < fw; i++) step(0, 1'b0, rb(), 0);
    step(0, 1'b1, rb(), 0);
    step(1, rb(), rb(), 0);
    case (o)
      6'h00: begin
        if (f == 6'h0C) begin
          for (int i = 0; i < aw; i++) step(12, rb(), 1'b0, 0);
          step(12, rb(), 1'b1, 1);
        end else begin
          step(6, rb(), rb(), 0);
          step(7, rb(), rb(), 1);
        end
      end
      6'h23: begin
        step(2, rb(), rb(), 0);
        for (int i = 0; i < mw; i++) step(3, 1'b0, rb(), 0);
        step(3, 1'b1, rb(), 0);
        step(4, rb(), rb(), 1);
      end
      6'h2B: begin
        step(2, rb(), rb(), 0);
        for (int i = 0; i < mw; i++) step(5, 1'b0, rb(), 0);
        step(5, 1'b1, rb(), 1);
      end
      6'h04, 6'h05: step(8, rb(), rb(), 1);
      6'h02:        step(9, rb(), rb(), 1);
      6'h08, 6'h0D: begin
        step(10, rb(), rb(), 0);
        step(11, rb(), rb(), 1);
      end
      default: for (int i = 0; i < 3; i++) step(13, rb(), rb(), 0);
    endcase
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, MAX_WAIT));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops [9];
    logic [5:0] f;
    int k;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h05;
    ops[5] = 6'h02; ops[6] = 6'h08; ops[7] = 6'h0D; ops[8] = 6'h00;

    #3;
    do_reset();

    run_instr(6'h00, 6'h20, 0, 0, 0);      // add
    run_instr(6'h23, 6'h00, 0, 3, 0);      // lw, 3 wait cycles
    run_instr(6'h05, 6'h00, 0, 0, 0);      // bne
    run_instr(6'h00, 6'h0C, 0, 0, 4);      // syscall, ack on 5th cycle
    run_instr(6'h2B, 6'h11, MAX_WAIT, MAX_WAIT, 0);  // ready exactly at the limit

    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 8));
      f = 6'($urandom_range(0, 63));
      if (k == 8) f = 6'h0C;
      else if (k == 0 && f == 6'h0C) f = 6'h20;
      run_instr(ops[k], f, rand_wait(), rand_wait(), int'($urandom_range(0, 6)));
    end

    for (int n = 0; n < 16; n++) run_instr(6'h02, 6'h00, 0, 0, 0);

    run_instr(6'h3F, 6'h00, 0, 0, 0);      // undefined opcode
    do_reset();

    op = 6'h00; funct = 6'h20;             // FETCH timeout
    for (int i = 0; i <= MAX_WAIT; i++) step(0, 1'b0, rb(), 0);
    for (int i = 0; i < 3; i++) step(13, 1'b1, 1'b1, 0);
    do_reset();

    op = 6'h23;                            // MEM_RD timeout
    step(0, 1'b1, 1'b0, 0);
    step(1, 1'b0, 1'b0, 0);
    step(2, 1'b0, 1'b0, 0);
    for (int i = 0; i <= MAX_WAIT; i++) step(3, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++) step(13, 1'b1, 1'b0, 0);
    do_reset();

    run_instr(6'h02, 6'h00, 0, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0, 0);
    op = 6'h23;                            // abandon lw mid-wait
    step(0, 1'b1, 1'b0, 0);
    step(1, 1'b0, 1'b0, 0);
    step(2, 1'b0, 1'b0, 0);
    step(3, 1'b0, 1'b0, 0);
    step(3, 1'b0, 1'b0, 0);
    do_reset();
    run_instr(6'h00, 6'h25, 1, 0, 0);

    @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
